// File: rtl/me_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : me_pkg
//  Brief    : Shared FSM encoding, geometry helpers and constants for the
//             full-search SAD motion estimator.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
package me_pkg;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_run   = 3'd1;
    localparam logic [2:0] c_st_drain = 3'd2;
    localparam logic [2:0] c_st_cmp   = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    // Fill bit for a clamped (saturated) lane distortion.
    localparam logic c_sat_fill = 1'b1;

    function automatic int win_side(input int blk, input int range);
        return blk + 2 * range;
    endfunction

    function automatic int num_passes(input int range, input int npe);
        return (2 * range / npe) * 2 * range;
    endfunction

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ref_aw(input int blk);
        return addr_w(blk * blk);
    endfunction

    function automatic int srch_aw(input int blk, input int range);
        return addr_w(win_side(blk, range) * win_side(blk, range));
    endfunction

endpackage
`default_nettype wire

// File: rtl/me_sad_lane.sv
`default_nettype none
// ============================================================================
//  Module   : me_sad_lane
//  Brief    : One SAD lane: |ref - srch| at PIX_W+1 bits into a sticky
//             saturating accumulator that reloads on the first pixel of a pass.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module me_sad_lane
    import me_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int DIST_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_valid,
    input  logic              i_first,
    input  logic [PIX_W-1:0]  i_ref,
    input  logic [PIX_W-1:0]  i_srch,
    output logic [DIST_W-1:0] o_dist
);

    logic [PIX_W:0]  w_a;
    logic [PIX_W:0]  w_b;
    logic [PIX_W:0]  w_diff;
    logic [DIST_W:0] w_ext;
    logic [DIST_W:0] w_base;
    logic [DIST_W:0] w_sum;

    assign w_a    = {1'b0, i_ref};
    assign w_b    = {1'b0, i_srch};
    assign w_diff = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
    assign w_ext  = (DIST_W+1)'(w_diff);
    assign w_base = i_first ? '0 : {1'b0, o_dist};
    assign w_sum  = w_base + w_ext;

    // A clamped lane stays clamped: any further non-zero term carries out again.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            o_dist <= '0;
        end else if (i_valid) begin
            o_dist <= w_sum[DIST_W] ? {DIST_W{c_sat_fill}} : w_sum[DIST_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/me_sad_search.sv
`default_nettype none
// ============================================================================
//  Module   : me_sad_search
//  Brief    : Full-search block matcher: NPE SAD lanes per pass, minimum SAD
//             and its motion vector reported with a start/busy/done handshake.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module me_sad_search
    import me_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int BLK    = 16,
    parameter int RANGE  = 8,
    parameter int NPE    = 16,
    parameter int DIST_W = 16
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    output logic [ref_aw(BLK)-1:0]              ref_addr,
    input  logic [PIX_W-1:0]                    ref_data,
    output logic [srch_aw(BLK, RANGE)-1:0]      srch_addr,
    input  logic [NPE*PIX_W-1:0]                srch_data,
    output logic                                busy,
    output logic                                done,
    output logic [DIST_W-1:0]                   best_dist,
    output logic [$clog2(RANGE):0]              mv_x,
    output logic [$clog2(RANGE):0]              mv_y
);

    localparam int c_w     = win_side(BLK, RANGE);
    localparam int c_ra_w  = ref_aw(BLK);
    localparam int c_sa_w  = srch_aw(BLK, RANGE);
    localparam int c_ndx   = 2 * RANGE / NPE;
    localparam int c_pos_w = addr_w(BLK);
    localparam int c_dy_w  = addr_w(2 * RANGE);
    localparam int c_dx_w  = addr_w(c_ndx);
    localparam int c_idx_w = addr_w(NPE);
    localparam int c_mv_w  = $clog2(RANGE) + 1;

    localparam logic [c_pos_w-1:0] c_pos_last = c_pos_w'(BLK - 1);
    localparam logic [c_dy_w-1:0]  c_dy_last  = c_dy_w'(2 * RANGE - 1);
    localparam logic [c_dx_w-1:0]  c_dx_last  = c_dx_w'(c_ndx - 1);
    localparam logic [c_mv_w-1:0]  c_mv_min   = c_mv_w'(-RANGE);

    logic [2:0]         r_state;
    logic [c_pos_w-1:0] r_row;
    logic [c_pos_w-1:0] r_col;
    logic [c_dy_w-1:0]  r_dyi;   // dy + RANGE
    logic [c_dx_w-1:0]  r_dxi;   // (dx0 + RANGE) / NPE
    logic               r_drain;
    logic               r_v1;
    logic               r_first1;

    logic [DIST_W-1:0]  w_dist [NPE];
    logic [DIST_W-1:0]  w_best;
    logic [c_idx_w-1:0] w_idx;
    logic               w_upd;

    assign ref_addr  = c_ra_w'(32'(r_row) * BLK + 32'(r_col));
    assign srch_addr = c_sa_w'((32'(r_row) + 32'(r_dyi)) * c_w + 32'(r_col) + 32'(r_dxi) * NPE);

    generate
        for (genvar g = 0; g < NPE; g++) begin : g_lane
            me_sad_lane #(
                .PIX_W  (PIX_W),
                .DIST_W (DIST_W)
            ) u_lane (
                .clock   (clock),
                .reset   (reset),
                .i_valid (r_v1),
                .i_first (r_first1),
                .i_ref   (ref_data),
                .i_srch  (srch_data[g*PIX_W +: PIX_W]),
                .o_dist  (w_dist[g])
            );
        end
    endgenerate

    // Ascending lane scan with strict less-than keeps the earliest tie.
    always_comb begin
        w_best = best_dist;
        w_idx  = '0;
        w_upd  = 1'b0;
        for (int k = 0; k < NPE; k++) begin
            if (w_dist[k] < w_best) begin
                w_best = w_dist[k];
                w_idx  = c_idx_w'(k);
                w_upd  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_row     <= '0;
            r_col     <= '0;
            r_dyi     <= '0;
            r_dxi     <= '0;
            r_drain   <= 1'b0;
            r_v1      <= 1'b0;
            r_first1  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            best_dist <= '1;
            mv_x      <= '0;
            mv_y      <= '0;
        end else begin
            // Data returns one cycle after its address, so qualifiers lag by one.
            r_v1     <= (r_state == c_st_run);
            r_first1 <= (r_state == c_st_run) && (r_row == '0) && (r_col == '0);
            done     <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state   <= c_st_run;
                        busy      <= 1'b1;
                        best_dist <= '1;
                        mv_x      <= c_mv_min;
                        mv_y      <= c_mv_min;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_dyi     <= '0;
                        r_dxi     <= '0;
                    end
                end
                c_st_run: begin
                    if (r_col == c_pos_last) begin
                        r_col <= '0;
                        if (r_row == c_pos_last) begin
                            r_row   <= '0;
                            r_drain <= 1'b0;
                            r_state <= c_st_drain;
                        end else begin
                            r_row <= r_row + c_pos_w'(1);
                        end
                    end else begin
                        r_col <= r_col + c_pos_w'(1);
                    end
                end
                c_st_drain: begin
                    r_drain <= 1'b1;
                    if (r_drain) begin
                        r_state <= c_st_cmp;
                    end
                end
                c_st_cmp: begin
                    if (w_upd) begin
                        best_dist <= w_best;
                        mv_x      <= c_mv_w'(32'(r_dxi) * NPE + 32'(w_idx) - RANGE);
                        mv_y      <= c_mv_w'(32'(r_dyi) - RANGE);
                    end
                    if ((r_dyi == c_dy_last) && (r_dxi == c_dx_last)) begin
                        r_state <= c_st_done;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_dyi   <= '0;
                        r_dxi   <= '0;
                    end else begin
                        r_state <= c_st_run;
                        if (r_dxi == c_dx_last) begin
                            r_dxi <= '0;
                            r_dyi <= r_dyi + c_dy_w'(1);
                        end else begin
                            r_dxi <= r_dxi + c_dx_w'(1);
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_me_sad_search.sv
`default_nettype none
// ============================================================================
//  Module   : tb_me_sad_search
//  Brief    : Self-checking bench for me_sad_search (default, DIST_W=8, NPE=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_me_sad_search;

    localparam int BLK   = 16;
    localparam int RANGE = 8;
    localparam int W     = BLK + 2 * RANGE;
    localparam int LAT_A = 4145;
    localparam int LAT_C = 16577;

    logic clock   = 1'b0;
    logic reset   = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic start_c = 1'b0;

    always #5 clock = ~clock;

    logic [7:0] ref_mem [BLK*BLK];
    logic [7:0] win_mem [W*W];

    logic [7:0]   ref_addr_a, ref_addr_b, ref_addr_c;
    logic [9:0]   srch_addr_a, srch_addr_b, srch_addr_c;
    logic [7:0]   ref_data_a, ref_data_b, ref_data_c;
    logic [127:0] srch_data_a, srch_data_b;
    logic [31:0]  srch_data_c;
    logic         busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic [15:0]  best_a, best_c;
    logic [7:0]   best_b;
    logic signed [3:0] mvx_a, mvy_a, mvx_b, mvy_b, mvx_c, mvy_c;

    me_sad_search dut_a (
        .clock(clock), .reset(reset), .start(start_a),
        .ref_addr(ref_addr_a), .ref_data(ref_data_a),
        .srch_addr(srch_addr_a), .srch_data(srch_data_a),
        .busy(busy_a), .done(done_a), .best_dist(best_a), .mv_x(mvx_a), .mv_y(mvy_a));

    me_sad_search #(.DIST_W(8)) dut_b (
        .clock(clock), .reset(reset), .start(start_b),
        .ref_addr(ref_addr_b), .ref_data(ref_data_b),
        .srch_addr(srch_addr_b), .srch_data(srch_data_b),
        .busy(busy_b), .done(done_b), .best_dist(best_b), .mv_x(mvx_b), .mv_y(mvy_b));

    me_sad_search #(.NPE(4)) dut_c (
        .clock(clock), .reset(reset), .start(start_c),
        .ref_addr(ref_addr_c), .ref_data(ref_data_c),
        .srch_addr(srch_addr_c), .srch_data(srch_data_c),
        .busy(busy_c), .done(done_c), .best_dist(best_c), .mv_x(mvx_c), .mv_y(mvy_c));

    function automatic logic [7:0] win_at(input int i);
        return (i < W * W) ? win_mem[i] : 8'h00;
    endfunction

    always @(posedge clock) begin
        ref_data_a <= ref_mem[ref_addr_a];
        ref_data_b <= ref_mem[ref_addr_b];
        ref_data_c <= ref_mem[ref_addr_c];
        for (int k = 0; k < 16; k++) begin
            srch_data_a[k*8 +: 8] <= win_at(int'(srch_addr_a) + k);
            srch_data_b[k*8 +: 8] <= win_at(int'(srch_addr_b) + k);
        end
        for (int k = 0; k < 4; k++) begin
            srch_data_c[k*8 +: 8] <= win_at(int'(srch_addr_c) + k);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Exhaustive SAD search straight from the definition, dy outer, dx inner.
    function automatic void model(input int dw, output int bd, output int mx, output int my);
        int sat, s, d;
        sat = (1 << dw) - 1;
        bd = sat; mx = -RANGE; my = -RANGE;
        for (int dy = -RANGE; dy < RANGE; dy++) begin
            for (int dx = -RANGE; dx < RANGE; dx++) begin
                s = 0;
                for (int r = 0; r < BLK; r++) begin
                    for (int c = 0; c < BLK; c++) begin
                        d = int'(ref_mem[r*BLK + c]) - int'(win_mem[(r + dy + RANGE) * W + c + dx + RANGE]);
                        s += (d < 0) ? -d : d;
                    end
                end
                if (s > sat) s = sat;
                if (s < bd) begin bd = s; mx = dx; my = dy; end
            end
        end
    endfunction

    // Cycle-level expectation for dut_a: handshake timing plus held results.
    bit m_busy = 0, m_done = 0;
    int m_cnt = 0, m_best = 65535, m_mx = 0, m_my = 0;
    int p_best = 0, p_mx = 0, p_my = 0;

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            m_busy = 0; m_done = 0; m_cnt = 0; m_best = 65535; m_mx = 0; m_my = 0;
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == LAT_A) begin
                m_busy = 0; m_done = 1; m_best = p_best; m_mx = p_mx; m_my = p_my;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (start_a) begin
            m_busy = 1; m_cnt = 1;
            model(16, p_best, p_mx, p_my);
        end
    end

    initial forever begin
        @(negedge clock);
        if (!reset) begin
            checks++;
            if (busy_a !== m_busy || done_a !== m_done ||
                (!m_busy && (int'(best_a) != m_best || int'(mvx_a) != m_mx || int'(mvy_a) != m_my))) begin
                errors++;
                $display("FAIL cycle_check t=%0t busy=%b exp %b done=%b exp %b best=%0d exp %0d mv=(%0d,%0d) exp (%0d,%0d)",
                         $time, busy_a, m_busy, done_a, m_done, best_a, m_best, mvx_a, mvy_a, m_mx, m_my);
            end
        end
    end

    task automatic fill_planted();
        for (int i = 0; i < W * W; i++) win_mem[i] = 8'($urandom);
        for (int r = 0; r < BLK; r++)
            for (int c = 0; c < BLK; c++)
                ref_mem[r*BLK + c] = win_mem[(r + 3 + RANGE) * W + c - 5 + RANGE];
    endtask

    task automatic fill_const(input logic [7:0] rv, input logic [7:0] wv);
        for (int i = 0; i < W * W; i++) win_mem[i] = wv;
        for (int i = 0; i < BLK * BLK; i++) ref_mem[i] = rv;
    endtask

    task automatic fill_random();
        for (int i = 0; i < W * W; i++) win_mem[i] = 8'($urandom);
        for (int i = 0; i < BLK * BLK; i++) ref_mem[i] = 8'($urandom);
    endtask

    // Cycle n is the n-th cycle after the edge that accepts start.
    task automatic run_a(input bit repulse, input bit with_b, input int rst_at,
                         output int done_cyc, output int pulses);
        @(negedge clock); start_a = 1; start_b = with_b;
        @(negedge clock); start_a = 0; start_b = 0;
        done_cyc = -1; pulses = 0;
        for (int n = 1; n <= LAT_A + 4; n++) begin
            if (done_a) begin
                pulses++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (rst_at == n) begin
                reset = 1; #1;
                chk("abort_busy", int'(busy_a), 0);
                chk("abort_done", int'(done_a), 0);
                chk("abort_best", int'(best_a), 65535);
                chk("abort_mv", int'({mvx_a, mvy_a}), 0);
                @(negedge clock); @(negedge clock);
                reset = 0;
                return;
            end
            start_a = repulse && (n == 100 || n == LAT_A);
            @(negedge clock);
        end
        start_a = 0;
    endtask

    int dc, np, eb, ex, ey;

    initial begin
        fill_const(8'h00, 8'h00);
        repeat (3) @(negedge clock);
        reset = 0;
        @(negedge clock);
        chk("reset_busy", int'(busy_a), 0);
        chk("reset_done", int'(done_a), 0);
        chk("reset_best", int'(best_a), 65535);
        chk("reset_mv", int'({mvx_a, mvy_a}), 0);
        chk("reset_addrs", int'(ref_addr_a) + int'(srch_addr_a), 0);

        // Planted block at (-5, +3).
        fill_planted();
        model(16, eb, ex, ey);
        chk("model_planted_best", eb, 0);
        chk("model_planted_mvx", ex, -5);
        chk("model_planted_mvy", ey, 3);
        run_a(0, 0, 0, dc, np);
        chk("t1_done_cycle", dc, LAT_A);
        chk("t1_done_pulses", np, 1);
        chk("t1_best", int'(best_a), 0);
        chk("t1_mvx", int'(mvx_a), -5);
        chk("t1_mvy", int'(mvy_a), 3);

        // Flat image: every SAD ties at zero.
        fill_const(8'h80, 8'h80);
        model(16, eb, ex, ey);
        chk("model_flat_mv", ex * 100 + ey, -808);
        run_a(0, 0, 0, dc, np);
        chk("t2_best", int'(best_a), 0);
        chk("t2_mvx", int'(mvx_a), -8);
        chk("t2_mvy", int'(mvy_a), -8);

        // Maximum distortion, 16-bit and saturating 8-bit.
        fill_const(8'hFF, 8'h00);
        model(16, eb, ex, ey);
        chk("model_max16", eb, 65280);
        model(8, eb, ex, ey);
        chk("model_max8", eb, 255);
        run_a(0, 1, 0, dc, np);
        chk("t3_best16", int'(best_a), 65280);
        chk("t3_mv16", int'(mvx_a) * 100 + int'(mvy_a), -808);
        chk("t3_best8", int'(best_b), 255);
        chk("t3_mv8", int'(mvx_b) * 100 + int'(mvy_b), -808);
        chk("t3_done8", int'(done_b) + int'(busy_b), 0);

        // start re-pulsed while busy and in the done cycle.
        fill_random();
        model(16, eb, ex, ey);
        run_a(1, 0, 0, dc, np);
        chk("t4_done_cycle", dc, LAT_A);
        chk("t4_done_pulses", np, 1);
        chk("t4_best", int'(best_a), eb);
        chk("t4_mv", int'(mvx_a) * 100 + int'(mvy_a), ex * 100 + ey);

        // Abort mid-search, then a clean rerun.
        fill_planted();
        run_a(0, 0, 2000, dc, np);
        chk("t5_no_done_before_abort", np, 0);
        repeat (5) @(negedge clock);
        run_a(0, 0, 0, dc, np);
        chk("t5_done_cycle", dc, LAT_A);
        chk("t5_best", int'(best_a), 0);
        chk("t5_mv", int'(mvx_a) * 100 + int'(mvy_a), -497);

        for (int t = 0; t < 2; t++) begin
            fill_random();
            run_a(0, 0, 0, dc, np);
            chk("rand_done_cycle", dc, LAT_A);
        end

        // Four-lane engine on the planted image.
        fill_planted();
        @(negedge clock); start_c = 1;
        @(negedge clock); start_c = 0;
        dc = -1; np = 0;
        for (int n = 1; n <= LAT_C + 4; n++) begin
            if (done_c) begin
                np++;
                if (dc < 0) dc = n;
            end
            if (n == 1 || n == 260 || n == 519 || n == 778)
                chk("c_srch_addr", int'(srch_addr_c), ((n - 1) / 259) * 4);
            @(negedge clock);
        end
        chk("c_done_cycle", dc, LAT_C);
        chk("c_done_pulses", np, 1);
        chk("c_best", int'(best_c), 0);
        chk("c_mv", int'(mvx_c) * 100 + int'(mvy_c), -497);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/me_sad_search.md
Name: me_sad_search

Overview:
- Parametrised full-search block-matching motion estimator. Next generation of the fixed 16x16 / ±8 / 8-bit engine.
- Computes the SAD between a BLK x BLK reference block and every candidate in a ±RANGE search window, then reports the minimum distortion and its motion vector.
- Uses NPE parallel SAD lanes fed by a wide search-memory port, with a start/busy/done handshake.
- Sits between the reference/search pixel memories and the downstream vector consumer.

Parameters:
- PIX_W, 8: pixel width in bits.
- BLK, 16: reference block side, in pixels.
- RANGE, 8: candidate offsets dx, dy in [-RANGE, RANGE-1]; the window side is W = BLK + 2*RANGE.
- NPE, 16: number of parallel SAD lanes. Must divide 2*RANGE.
- DIST_W, 16: distortion accumulator width. Saturating.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request. Sampled only when busy=0.
- ref_addr  out  clog2(BLK*BLK)  reference pixel address, r*BLK + c.
- ref_data  in  PIX_W  reference pixel. Arrives one cycle after its address.
- srch_addr  out  clog2(W*W)  address of the first pixel of the search segment, row*W + col.
- srch_data  in  NPE*PIX_W  NPE consecutive row pixels, one cycle after the address. Lane k is at [k*PIX_W +: PIX_W].
- busy  out  1  high from the start-accept edge until done.
- done  out  1  one-cycle pulse when results are valid.
- best_dist  out  DIST_W  minimum SAD found.
- mv_x  out  clog2(RANGE)+1  signed dx of best_dist.
- mv_y  out  clog2(RANGE)+1  signed dy of best_dist.

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE.
  - busy=0, done=0, best_dist=all-ones, mv_x=mv_y=0.
  - Addresses driven to 0. Lane accumulators cleared.
- Scan order:
  - A pass covers a fixed dy and NPE adjacent dx values, dx0 .. dx0+NPE-1.
  - dy runs from -RANGE up to RANGE-1, outer loop.
  - dx0 runs from -RANGE in steps of NPE, inner loop.
  - PASSES = (2*RANGE/NPE) * 2*RANGE.
- FSM states: IDLE, RUN, DRAIN, CMP, DONE.
- IDLE:
  - On start=1: go to RUN, set busy=1, set best_dist=all-ones, reset the pass index.
- RUN:
  - Lasts BLK*BLK cycles. Pixel index (r, c) is raster order.
  - ref_addr = r*BLK + c.
  - srch_addr = (r + dy + RANGE)*W + (c + dx0 + RANGE).
  - A segment never crosses a row end.
- DRAIN:
  - Lasts 2 cycles: memory latency plus the accumulate register.
- CMP:
  - Lasts 1 cycle. Lanes are scanned from 0 to NPE-1.
  - A lane replaces the best only if it is strictly less than the current best. Ties keep the earliest candidate in scan order.
  - On replacement, mv_x = dx0 + k and mv_y = dy.
  - Next state is RUN if passes remain, otherwise DONE.
- DONE:
  - done=1 and busy=0 in this cycle, then IDLE.
  - Outputs hold until the next accepted start or reset.
- Lane arithmetic:
  - |ref - srch| is computed at PIX_W+1 bits, so the result is never negative and never wraps.
  - The first pixel of a pass loads the difference; later pixels add to it.
  - On overflow past DIST_W bits, the lane clamps to all-ones and stays there (sticky) until the next pass load.
- Latency: start-accept edge to done = PASSES*(BLK*BLK+3)+1 cycles. With defaults: 16*259+1 = 4145.
- start while busy: ignored, with no effect on the scan or outputs.
- start in the DONE cycle: ignored. It is accepted from IDLE onward.
- Reset mid-operation: immediate abort. No done pulse. The next start runs a full clean search.

Decomposition:
- Package me_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, CMP, DONE);
  - functions for W, PASSES and the address widths;
  - the saturation constant.
- Sub-module me_sad_lane, instantiated NPE times. It contains:
  - the abs-difference logic;
  - the saturating accumulator;
  - the load-on-first-pixel control.
- The top level holds the FSM, the pixel/pass counters, address generation and the lane compare.

Test Plan:
- Defaults; random window; ref = window block at dx=-5, dy=+3 -> best_dist=0, mv_x=-5, mv_y=3; done at cycle 4145, exactly one pulse.
- Ref and window all 0x80 -> every SAD is 0; tie rule gives best_dist=0, mv_x=-8, mv_y=-8.
- Ref all 0xFF, window all 0x00 -> best_dist=65280 with DIST_W=16; with DIST_W=8, best_dist=255 (saturated); mv=(-8,-8).
- start re-pulsed at cycles 100 and 4145 -> both ignored; busy is unbroken until done at 4145; outputs unchanged.
- reset asserted at cycle 2000 -> busy=0, best_dist=0xFF.., mv=0 immediately, no done; the following start completes in 4145 cycles with the correct result.
- NPE=4, same stimulus as the first test -> identical result; done at 64*259+1 = 16577; srch_addr steps dx0 through -8, -4, 0, 4.
